// File: rtl/maf_normalizer.sv
// maf_normalizer: two-stage post-adder normalizer for the FMA datapath.
// It shifts left by the leading-zero count, or right by one on carry-out, and has an elastic valid/ready handshake.
module maf_normalizer #(
  parameter int EW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [47:0]   sum,
  input  logic          cout,
  input  logic [EW-1:0] exp_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [47:0]   mant,
  output logic [EW-1:0] exp_out,
  output logic          sticky,
  output logic          zero,
  output logic          uf,
  output logic          of
);
  localparam logic [EW:0] EMAX = {1'b0, {EW{1'b1}}};
  logic          s1_valid_q, s1_valid_d, s1_cout_q, s1_cout_d;
  logic [47:0]   s1_sum_q, s1_sum_d;
  logic [EW-1:0] s1_exp_q, s1_exp_d;
  logic [5:0]    s1_lzc_q, s1_lzc_d, lzc;
  logic          out_valid_q, out_valid_d, sticky_q, sticky_d, zero_q, zero_d, uf_q, uf_d, of_q, of_d;
  logic [47:0]   mant_q, mant_d;
  logic [EW-1:0] exp_q, exp_d;
  logic          s1_en, s2_en, ld1, ld2, is_zero, is_of, is_uf;
  logic [EW:0]   e_wide, lz_wide;
  logic [47:0]   r_mant;
  logic [EW-1:0] r_exp;
  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;
  assign ld1      = s1_en && in_valid;
  assign ld2      = s2_en && s1_valid_q;
  always_comb begin
    lzc = 6'd48;
    for (int i = 0; i < 48; i++)
      if (sum[i]) lzc = 6'(47 - i);
  end
  always_comb begin
    s1_valid_d = s1_en ? in_valid : s1_valid_q;
    s1_cout_d  = ld1 ? cout : s1_cout_q;
    s1_sum_d   = ld1 ? sum : s1_sum_q;
    s1_exp_d   = ld1 ? exp_in : s1_exp_q;
    s1_lzc_d   = ld1 ? lzc : s1_lzc_q;
  end
  // Range checks use a widened exponent so the uf/of decisions cannot wrap.
  always_comb begin
    e_wide  = {1'b0, s1_exp_q};
    lz_wide = (EW+1)'(s1_lzc_q);
    is_zero = !s1_cout_q && (s1_sum_q == 48'd0);
    is_of   = s1_cout_q && (e_wide >= EMAX - 1'b1);
    is_uf   = !s1_cout_q && !is_zero && (e_wide <= lz_wide);
    r_mant  = (is_zero || is_of) ? 48'd0 :
              s1_cout_q ? {1'b1, s1_sum_q[47:1]} :
              is_uf ? s1_sum_q << ((s1_exp_q == '0) ? '0 : s1_exp_q - 1'b1) :
              s1_sum_q << s1_lzc_q;
    r_exp   = (is_zero || is_uf) ? '0 :
              is_of ? {EW{1'b1}} :
              s1_cout_q ? s1_exp_q + 1'b1 :
              s1_exp_q - EW'(s1_lzc_q);
  end
  always_comb begin
    out_valid_d = s2_en ? s1_valid_q : out_valid_q;
    mant_d      = ld2 ? r_mant : mant_q;
    exp_d       = ld2 ? r_exp : exp_q;
    sticky_d    = ld2 ? (s1_cout_q && s1_sum_q[0]) : sticky_q;
    zero_d      = ld2 ? is_zero : zero_q;
    uf_d        = ld2 ? is_uf : uf_q;
    of_d        = ld2 ? is_of : of_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_cout_q   <= 1'b0;
      s1_sum_q    <= '0;
      s1_exp_q    <= '0;
      s1_lzc_q    <= '0;
      out_valid_q <= 1'b0;
      mant_q      <= '0;
      exp_q       <= '0;
      sticky_q    <= 1'b0;
      zero_q      <= 1'b0;
      uf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cout_q   <= s1_cout_d;
      s1_sum_q    <= s1_sum_d;
      s1_exp_q    <= s1_exp_d;
      s1_lzc_q    <= s1_lzc_d;
      out_valid_q <= out_valid_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sticky_q    <= sticky_d;
      zero_q      <= zero_d;
      uf_q        <= uf_d;
      of_q        <= of_d;
    end
  end
  assign out_valid = out_valid_q;
  assign mant      = mant_q;
  assign exp_out   = exp_q;
  assign sticky    = sticky_q;
  assign zero      = zero_q;
  assign uf        = uf_q;
  assign of        = of_q;
endmodule

// File: tb/tb_maf_normalizer.sv
// tb_maf_normalizer: directed and random checks of maf_normalizer against an arithmetic reference model.
module tb_maf_normalizer;
  localparam int EW = 10;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cout_i = 1'b0;
  logic [47:0] sum_i = '0;
  logic [EW-1:0] exp_i = '0;
  logic in_ready, out_valid, sticky, zero, uf, of;
  logic [47:0] mant;
  logic [EW-1:0] exp_out;
  logic [61:0] obs, prev_obs;
  logic [63:0] r;
  logic [61:0] q[$];
  logic acc, seen_block, prev_stall;
  int n_assert = 0, n_fail = 0, n_out = 0, sent;

  maf_normalizer #(.EW(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum_i), .cout(cout_i), .exp_in(exp_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant(mant), .exp_out(exp_out), .sticky(sticky), .zero(zero), .uf(uf), .of(of)
  );

  always #5 clk = ~clk;
  assign obs = {mant, exp_out, sticky, zero, uf, of};

  // Result packed as {mant, exp, sticky, zero, uf, of}.
  function automatic logic [61:0] model(logic [47:0] s, logic c, int e);
    int p = -1;
    int lz;
    int emax = (1 << EW) - 1;
    for (int i = 0; i < 48; i++) if (s[i]) p = i;
    lz = 47 - p;
    if (!c && s == 0) return {48'd0, 10'd0, 4'b0100};
    if (c && e >= emax - 1) return {48'd0, 10'(emax), s[0], 3'b001};
    if (c) return {1'b1, s[47:1], 10'(e + 1), s[0], 3'b000};
    if (e <= lz) return {s << ((e == 0) ? 0 : e - 1), 10'd0, 4'b0010};
    return {s << lz, 10'(e - lz), 4'b0000};
  endfunction

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("in_ready", in_ready, (q.size() < 2) || out_ready);
    if (prev_stall) chk("stall_stable", obs, prev_obs);
    prev_stall = out_valid && !out_ready;
    prev_obs = obs;
    acc = in_valid && in_ready;
    if (in_valid && !in_ready) seen_block = 1'b1;
    if (out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) chk("out_without_beat", 64'(q.size()), 1);
      else chk("result", obs, q.pop_front());
    end
    if (acc) q.push_back(model(sum_i, cout_i, int'(exp_i)));
    @(posedge clk);
    #1;
  endtask

  task automatic dir(string tag, logic [47:0] s, logic c, logic [EW-1:0] e, logic [61:0] want);
    sum_i = s; cout_i = c; exp_i = e; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    step();
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, obs, want);
    step();
  endtask

  initial begin
    prev_stall = 1'b0; seen_block = 1'b0; acc = 1'b0; prev_obs = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", obs, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    dir("normal",    48'h1,   1'b0, 10'd100,  {48'h800000000000, 10'd53, 4'b0000});
    dir("carry",     48'h1,   1'b1, 10'd100,  {48'h800000000000, 10'd101, 4'b1000});
    dir("zero",      48'h0,   1'b0, 10'd77,   {48'h0, 10'd0, 4'b0100});
    dir("overflow",  48'h0,   1'b1, 10'd1022, {48'h0, 10'd1023, 4'b0001});
    dir("carry_max", 48'h3,   1'b1, 10'd1021, {48'h800000000001, 10'd1022, 4'b1000});
    dir("underflow", 48'h1,   1'b0, 10'd10,   {48'h000000000200, 10'd0, 4'b0010});
    dir("uf_edge",   48'h1,   1'b0, 10'd47,   {48'h400000000000, 10'd0, 4'b0010});
    dir("norm_edge", 48'h1,   1'b0, 10'd48,   {48'h800000000000, 10'd1, 4'b0000});
    dir("uf_exp0",   48'h123, 1'b0, 10'd0,    {48'h000000000123, 10'd0, 4'b0010});
    // Backpressure: out_ready low for four cycles while five beats stream in.
    sent = 0; n_out = 0; seen_block = 1'b0;
    for (int c = 0; c < 40 && (sent < 5 || q.size() != 0); c++) begin
      out_ready = !(c >= 2 && c < 6);
      in_valid = sent < 5;
      sum_i = 48'h1 << (sent * 7); cout_i = (sent == 3); exp_i = 10'(200 + sent);
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_in_ready_dropped", seen_block, 1);
    chk("bp_out_count", n_out, 5);
    chk("bp_all_drained", q.size(), 0);
    // Reset with two beats in flight.
    sum_i = 48'hABC; cout_i = 1'b0; exp_i = 10'd300; in_valid = 1'b1;
    step();
    sum_i = 48'hDEF;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_outputs", obs, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete(); prev_stall = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    dir("post_rst", 48'h000000008000, 1'b0, 10'd500, {48'h800000000000, 10'd468, 4'b0000});
    // Random traffic with random backpressure.
    n_out = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      r = {$urandom, $urandom};
      sum_i = r[47:0] >> ($urandom % 49);
      cout_i = ($urandom % 6) == 0;
      case ($urandom % 4)
        0: exp_i = 10'($urandom_range(0, 50));
        1: exp_i = 10'($urandom_range(1018, 1023));
        default: exp_i = 10'($urandom % 1024);
      endcase
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++) step();
    chk("random_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
